// File: rtl/mat_acc_pkg.sv
// -----------------------------------------------------------------------------
// mat_acc_pkg
// Shared types and constants for the matrix-accelerator APB front end.
//   word_t    : one buffer word, four packed 8-bit lanes
//   region_e  : PADDR[11:10] address regions (A, B, result, CSR)
//   CSR_*     : CSR word indices (PADDR[9:2]) for CTRL/STATUS/CYCLES
//   CTRL_*/ST_*: bit positions inside CTRL and STATUS
//   state_t   : sequencer states
// -----------------------------------------------------------------------------
package mat_acc_pkg;

   typedef logic [3:0][7:0] word_t;

   typedef enum logic [1:0] {
      REG_A   = 2'd0,
      REG_B   = 2'd1,
      REG_C   = 2'd2,
      REG_CSR = 2'd3
   } region_e;

   // CSR byte offsets 0x0/0x4/0x8 expressed as word indices
   localparam logic [7:0] CSR_CTRL   = 8'h00;
   localparam logic [7:0] CSR_STATUS = 8'h01;
   localparam logic [7:0] CSR_CYCLES = 8'h02;

   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic logic idx_in_range(input logic [7:0] idx, input int depth);
      return int'(idx) < depth;
   endfunction

endpackage

// File: rtl/mat_acc_seq.sv
// -----------------------------------------------------------------------------
// mat_acc_seq
// Run sequencer for the multiplier handshake: FSM, cycle counter, timeout and
// sticky done/err flags.
//   go        in   start request (only acted on in IDLE)
//   clr_done  in   write-1-to-clear of done_flag
//   clr_err   in   write-1-to-clear of err_flag
//   done_i    in   multiplier completion
//   start_o   out  run request, high for every RUN cycle
//   capture   out  one-cycle strobe: copy mat_C_i into the result buffer
//   busy      out  state != IDLE
//   done_flag out  run completed normally
//   err_flag  out  run aborted by timeout
//   cycles    out  RUN cycle count of the last/current run (saturating)
// -----------------------------------------------------------------------------
module mat_acc_seq
   import mat_acc_pkg::*;
#(
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic             clr_done,
   input  logic             clr_err,
   input  logic             done_i,
   output logic             start_o,
   output logic             capture,
   output logic             busy,
   output logic             done_flag,
   output logic             err_flag,
   output logic [CNT_W-1:0] cycles
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cycles_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cycles_q <= cycles_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cycles_d = cycles_q;
      // Clears are applied first so that any set below overrides them
      done_d   = done_q & ~clr_done;
      err_d    = err_q & ~clr_err;
      capture  = 1'b0;

      case (state_q)
         IDLE: begin
            if (go) begin
               state_d  = RUN;
               cycles_d = '0;
               done_d   = 1'b0;
               err_d    = 1'b0;
            end
         end
         RUN: begin
            if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
            if (done_i) begin
               capture = 1'b1;
               done_d  = 1'b1;
               state_d = DRAIN;
            end else if (cycles_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Wait for the multiplier to drop done before allowing a new run
            if (!done_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign start_o   = (state_q == RUN);
   assign busy      = (state_q != IDLE);
   assign done_flag = done_q;
   assign err_flag  = err_q;
   assign cycles    = cycles_q;

endmodule

// File: rtl/mat_acc_apb_if.sv
// -----------------------------------------------------------------------------
// mat_acc_apb_if
// APB responder in front of the matrix multiplier: A/B operand buffers,
// result buffer, CSRs and interrupt. Zero wait states.
//   clk, rst_n            clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE  APB request
//   PRDATA/PREADY/PSLVERR             APB response (combinational)
//   mat_A_o/mat_B_o       operand buffers to the multiplier
//   mat_C_i               multiplier result, captured on completion
//   start_o/done_i        multiplier handshake
//   irq_o                 level interrupt (done|err) & irq_en
// -----------------------------------------------------------------------------
module mat_acc_apb_if
   import mat_acc_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] PADDR,
   input  logic [31:0] PWDATA,
   input  logic        PWRITE,
   input  logic        PSEL,
   input  logic        PENABLE,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output word_t       mat_A_o [DEPTH],
   output word_t       mat_B_o [DEPTH],
   input  word_t       mat_C_i [DEPTH],
   output logic        start_o,
   input  logic        done_i,
   output logic        irq_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   word_t            a_q [DEPTH];
   word_t            a_d [DEPTH];
   word_t            b_q [DEPTH];
   word_t            b_d [DEPTH];
   word_t            c_q [DEPTH];
   word_t            c_d [DEPTH];
   logic             irq_en_q, irq_en_d;

   logic             access;
   region_e          region;
   logic [7:0]       idx;
   logic [AW-1:0]    widx;
   logic             idx_ok;
   logic             err, wr_a, wr_b, go, clr_done, clr_err;
   logic [31:0]      rdata;
   logic             busy, capture, done_flag, err_flag;
   logic [CNT_W-1:0] cycles;
   logic             unused_addr;

   assign access      = PSEL & PENABLE;
   assign region      = region_e'(PADDR[11:10]);
   assign idx         = PADDR[9:2];
   assign widx        = idx[AW-1:0];
   assign idx_ok      = idx_in_range(idx, DEPTH);
   assign unused_addr = ^PADDR[1:0];

   // Decode. Any transfer flagged with PSLVERR has no side effect at all.
   always_comb begin
      err      = 1'b0;
      rdata    = '0;
      wr_a     = 1'b0;
      wr_b     = 1'b0;
      go       = 1'b0;
      clr_done = 1'b0;
      clr_err  = 1'b0;
      irq_en_d = irq_en_q;
      if (access) begin
         if (!idx_ok) begin
            err = 1'b1;
         end else if (PWRITE) begin
            case (region)
               REG_A:   if (busy) err = 1'b1; else wr_a = 1'b1;
               REG_B:   if (busy) err = 1'b1; else wr_b = 1'b1;
               REG_C:   err = 1'b1;
               REG_CSR: begin
                  case (idx)
                     CSR_CTRL: begin
                        if (PWDATA[CTRL_START] && busy) begin
                           err = 1'b1;
                        end else begin
                           go       = PWDATA[CTRL_START];
                           irq_en_d = PWDATA[CTRL_IRQ_EN];
                        end
                     end
                     CSR_STATUS: begin
                        clr_done = PWDATA[ST_DONE];
                        clr_err  = PWDATA[ST_ERR];
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end else begin
            case (region)
               REG_A:   rdata = a_q[widx];
               REG_B:   rdata = b_q[widx];
               REG_C:   rdata = c_q[widx];
               REG_CSR: begin
                  case (idx)
                     CSR_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
                     CSR_STATUS: begin
                        rdata[ST_BUSY] = busy;
                        rdata[ST_DONE] = done_flag;
                        rdata[ST_ERR]  = err_flag;
                     end
                     CSR_CYCLES: rdata = 32'(cycles);
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign PRDATA  = rdata;
   assign PSLVERR = err;
   assign PREADY  = 1'b1;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
         assign a_d[gi]     = (wr_a && widx == AW'(gi)) ? word_t'(PWDATA) : a_q[gi];
         assign b_d[gi]     = (wr_b && widx == AW'(gi)) ? word_t'(PWDATA) : b_q[gi];
         assign c_d[gi]     = capture ? mat_C_i[gi] : c_q[gi];
         assign mat_A_o[gi] = a_q[gi];
         assign mat_B_o[gi] = b_q[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            c_q[i] <= '0;
         end
         irq_en_q <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         irq_en_q <= irq_en_d;
      end
   end

   mat_acc_seq #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (go),
      .clr_done  (clr_done),
      .clr_err   (clr_err),
      .done_i    (done_i),
      .start_o   (start_o),
      .capture   (capture),
      .busy      (busy),
      .done_flag (done_flag),
      .err_flag  (err_flag),
      .cycles    (cycles)
   );

   assign irq_o = (done_flag | err_flag) & irq_en_q;

endmodule

// File: tb/tb_mat_acc_apb_if.sv
// -----------------------------------------------------------------------------
// tb_mat_acc_apb_if
// Directed/randomized bench for mat_acc_apb_if with a mock multiplier that
// computes lane-wise 8-bit products of A and B and raises done a fixed number
// of cycles after start.
// -----------------------------------------------------------------------------
module tb_mat_acc_apb_if;
   import mat_acc_pkg::*;

   localparam int DEPTH   = 64;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 16;
   localparam int DONE_AFTER = 10;

   localparam logic [11:0] A_CTRL   = 12'hC00;
   localparam logic [11:0] A_STATUS = 12'hC04;
   localparam logic [11:0] A_CYCLES = 12'hC08;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic        PWRITE = 1'b0;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   word_t       mat_A_o [DEPTH];
   word_t       mat_B_o [DEPTH];
   word_t       mat_C_i [DEPTH];
   logic        start_o;
   logic        done_i = 1'b0;
   logic        irq_o;

   int vectors = 0;
   int miscompares = 0;

   // Mock state: written only by the mock process
   int   run_cnt = 0;
   int   start_hi = 0;
   int   pulses = 0;
   logic prev_start = 1'b0;
   // Mock controls: written only by the stimulus process
   logic mock_en = 1'b0;
   logic force_done = 1'b0;

   // Reference model
   word_t ref_a [DEPTH];
   word_t ref_b [DEPTH];
   word_t ref_c [DEPTH];

   always #5 clk = ~clk;

   mat_acc_apb_if #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PWRITE  (PWRITE),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .mat_A_o (mat_A_o),
      .mat_B_o (mat_B_o),
      .mat_C_i (mat_C_i),
      .start_o (start_o),
      .done_i  (done_i),
      .irq_o   (irq_o)
   );

   function automatic word_t lane_mul(input word_t a, input word_t b);
      word_t r;
      logic [15:0] p;
      for (int l = 0; l < 4; l++) begin
         p = 16'(a[l]) * 16'(b[l]);
         r[l] = p[7:0];
      end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) mat_C_i[i] = lane_mul(mat_A_o[i], mat_B_o[i]);
   end

   // Mock multiplier handshake, evaluated away from the active edge
   always @(negedge clk) begin
      if (start_o) begin
         run_cnt = run_cnt + 1;
         start_hi = start_hi + 1;
         if (!prev_start) pulses = pulses + 1;
      end else begin
         run_cnt = 0;
      end
      prev_start = start_o;
      done_i = force_done || (mock_en && start_o && run_cnt > DONE_AFTER);
   end

   function automatic logic [11:0] ad(input logic [1:0] rg, input int i);
      return {rg, 8'(i), 2'b00};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic e);
      @(posedge clk); #1;
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(negedge clk);
      e = PSLVERR;
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
      @(posedge clk); #1;
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(negedge clk);
      d = PRDATA;
      e = PSLVERR;
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] d;
      logic e;
      int n = 0;
      do begin
         apb_read(A_STATUS, d, e);
         n++;
      end while (d[ST_BUSY] && n < 100);
      check({tag, " busy cleared"}, {31'b0, d[ST_BUSY]}, 32'h0);
   endtask

   task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp,
                           input logic exp_err);
      logic [31:0] d;
      logic e;
      apb_read(a, d, e);
      check(tag, d, exp);
      check({tag, " pslverr"}, {31'b0, e}, {31'b0, exp_err});
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e;
      logic [31:0] d;
      int          idx;
      int          base_hi, base_p;

      for (int i = 0; i < DEPTH; i++) begin
         ref_a[i] = '0; ref_b[i] = '0; ref_c[i] = '0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset start_o", {31'b0, start_o}, 32'h0);
      check("reset irq_o", {31'b0, irq_o}, 32'h0);
      check("reset PSLVERR", {31'b0, PSLVERR}, 32'h0);
      check("reset PRDATA", PRDATA, 32'h0);
      #1 rst_n = 1'b1;
      rd_check("reset STATUS", A_STATUS, 32'h0, 1'b0);
      rd_check("reset CYCLES", A_CYCLES, 32'h0, 1'b0);
      rd_check("reset A[0]", ad(2'd0, 0), 32'h0, 1'b0);
      rd_check("reset C[0]", ad(2'd2, 0), 32'h0, 1'b0);

      // Operand fill: fixed word 0, random words elsewhere (index 5 left at 0)
      for (int k = 0; k < 8; k++) begin
         idx = (k == 0) ? 0 : int'($urandom_range(6, DEPTH - 1));
         ref_a[idx] = (k == 0) ? word_t'(32'h02020202) : word_t'($urandom);
         ref_b[idx] = (k == 0) ? word_t'(32'h04040404) : word_t'($urandom);
         apb_write(ad(2'd0, idx), ref_a[idx], e);
         check($sformatf("wr A[%0d] pslverr", idx), {31'b0, e}, 32'h0);
         apb_write(ad(2'd1, idx), ref_b[idx], e);
         rd_check($sformatf("rd A[%0d]", idx), ad(2'd0, idx), ref_a[idx], 1'b0);
         rd_check($sformatf("rd B[%0d]", idx), ad(2'd1, idx), ref_b[idx], 1'b0);
      end

      // Normal run with irq enabled; illegal writes while busy
      mock_en = 1'b1;
      base_hi = start_hi;
      base_p  = pulses;
      apb_write(A_CTRL, 32'h3, e);
      check("start pslverr", {31'b0, e}, 32'h0);
      apb_write(ad(2'd0, 5), 32'hFFFF_FFFF, e);
      check("busy wr A[5] pslverr", {31'b0, e}, 32'h1);
      apb_write(A_CTRL, 32'h1, e);
      check("busy start pslverr", {31'b0, e}, 32'h1);
      wait_idle("run1");
      for (int i = 0; i < DEPTH; i++) ref_c[i] = lane_mul(ref_a[i], ref_b[i]);
      check("run1 start_o cycles", 32'(start_hi - base_hi), 32'd11);
      check("run1 start pulses", 32'(pulses - base_p), 32'd1);
      check("run1 irq_o", {31'b0, irq_o}, 32'h1);
      rd_check("run1 STATUS", A_STATUS, 32'h2, 1'b0);
      rd_check("run1 CYCLES", A_CYCLES, 32'd11, 1'b0);
      rd_check("run1 C[0]", ad(2'd2, 0), 32'h08080808, 1'b0);
      rd_check("run1 A[5]", ad(2'd0, 5), ref_a[5], 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         apb_read(ad(2'd2, i), d, e);
         check($sformatf("run1 C[%0d]", i), d, ref_c[i]);
      end

      apb_write(A_STATUS, 32'h2, e);
      check("clr done irq_o", {31'b0, irq_o}, 32'h0);
      rd_check("clr done STATUS", A_STATUS, 32'h0, 1'b0);

      // done_i high while idle must be ignored
      force_done = 1'b1;
      repeat (3) @(posedge clk);
      rd_check("idle done STATUS", A_STATUS, 32'h0, 1'b0);
      force_done = 1'b0;
      repeat (2) @(posedge clk);

      // Timeout run: changed operand must not reach the result buffer
      ref_a[0] = ref_a[0] ^ word_t'(32'h01010101);
      apb_write(ad(2'd0, 0), ref_a[0], e);
      mock_en = 1'b0;
      base_hi = start_hi;
      apb_write(A_CTRL, 32'h1, e);
      wait_idle("timeout");
      check("timeout start_o cycles", 32'(start_hi - base_hi), 32'd16);
      rd_check("timeout STATUS", A_STATUS, 32'h4, 1'b0);
      rd_check("timeout CYCLES", A_CYCLES, 32'd16, 1'b0);
      rd_check("timeout C[0]", ad(2'd2, 0), ref_c[0], 1'b0);
      check("timeout irq masked", {31'b0, irq_o}, 32'h0);
      apb_write(A_CTRL, 32'h2, e);
      check("timeout irq_o", {31'b0, irq_o}, 32'h1);
      apb_write(A_STATUS, 32'h4, e);
      check("clr err irq_o", {31'b0, irq_o}, 32'h0);

      // Illegal accesses
      apb_write(12'h80C, 32'hDEAD_BEEF, e);
      check("wr C[3] pslverr", {31'b0, e}, 32'h1);
      rd_check("C[3] unchanged", ad(2'd2, 3), ref_c[3], 1'b0);
      apb_write(12'h100, 32'hCAFE_F00D, e);
      check("wr idx64 pslverr", {31'b0, e}, 32'h1);
      rd_check("rd idx64", 12'h100, 32'h0, 1'b1);
      rd_check("A[0] after bad wr", ad(2'd0, 0), ref_a[0], 1'b0);
      rd_check("STATUS after bad", A_STATUS, 32'h0, 1'b0);
      rd_check("CTRL readback", A_CTRL, 32'h2, 1'b0);

      // Reset in the middle of a run
      mock_en = 1'b1;
      apb_write(A_CTRL, 32'h1, e);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrun start_o", {31'b0, start_o}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset start_o", {31'b0, start_o}, 32'h0);
      check("async reset irq_o", {31'b0, irq_o}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         ref_a[i] = '0; ref_b[i] = '0; ref_c[i] = '0;
      end
      rd_check("post-reset STATUS", A_STATUS, 32'h0, 1'b0);
      rd_check("post-reset CYCLES", A_CYCLES, 32'h0, 1'b0);
      rd_check("post-reset CTRL", A_CTRL, 32'h0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         apb_read(ad(2'd0, i), d, e);
         check($sformatf("post-reset A[%0d]", i), d, ref_a[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
